// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default bit period, parity encoding and TX FSM states.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  // Default clock cycles per serial bit, shared with the receiver and its baud-rate generator.
  localparam int unsigned BAUD_RATE_DEFAULT = 10416;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Per-frame bit timer: counts 0..BAUD_RATE_NUMBER-1 while enabled and flags the last cycle of a bit.
module uart_tx_baud_counter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE_NUMBER = BAUD_RATE_DEFAULT
) (
  input  logic clk_in,
  input  logic rst,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CntW = $clog2(BAUD_RATE_NUMBER);
  localparam logic [CntW-1:0] LastCnt = CntW'(BAUD_RATE_NUMBER - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign bit_done = enable && (cnt_q == LastCnt);

  // Held at zero while disabled so every frame starts with a fresh bit phase.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!enable || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready byte intake, LSB-first framing with optional parity, 1 or 2 stops.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_RATE_NUMBER = BAUD_RATE_DEFAULT,
  parameter int unsigned PARITY           = PARITY_NONE,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy
);

  localparam int unsigned IdxW      = $clog2(DATA_BITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_BITS - 1);
  localparam bit ParityEn  = (PARITY != PARITY_NONE);
  localparam bit ParityOdd = (PARITY == PARITY_ODD);
  localparam logic LastStop = 1'(STOP_BITS - 1);

  tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic stop_cnt_q, stop_cnt_d;
  logic parity_q, parity_d;
  logic tx_q, tx_d;
  logic ready_q, ready_d;
  logic bit_done;

  uart_tx_baud_counter #(
    .BAUD_RATE_NUMBER(BAUD_RATE_NUMBER)
  ) u_baud (
    .clk_in  (clk_in),
    .rst     (rst),
    .enable  (state_q != StIdle),
    .bit_done(bit_done)
  );

  // tx_d is the level for the bit that begins after this edge, keeping tx fully registered.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    unique case (state_q)
      StIdle: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (tx_valid && ready_q) begin
          shift_d  = tx_data;
          parity_d = (^tx_data) ^ ParityOdd;
          state_d  = StStart;
          tx_d     = 1'b0;
          ready_d  = 1'b0;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastIdx) begin
            if (ParityEn) begin
              state_d = StParity;
              tx_d    = parity_q;
            end else begin
              state_d    = StStop;
              stop_cnt_d = 1'b0;
              tx_d       = 1'b1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
            tx_d  = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d    = StStop;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
        end
      end
      StStop: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (stop_cnt_q == LastStop) begin
            state_d = StIdle;
            ready_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = ~ready_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: five configurations on one clock, table vectors plus corner sequences.
module tb_uart_transmitter;

  localparam int NInst = 5;

  logic       clk = 1'b0;
  logic [4:0] rst;
  logic [4:0] valid;
  logic [4:0] ready;
  logic [4:0] tx;
  logic [4:0] busy;
  logic [7:0] data [NInst];

  int n_cmp = 0;
  int n_bad = 0;

  // Instance configs: bit period, parity enabled, stop bits.
  int cfg_b [NInst] = '{16, 4, 4, 4, 8};
  bit cfg_p [NInst] = '{0, 1, 1, 0, 0};
  int cfg_s [NInst] = '{1, 1, 2, 1, 1};

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       par;
    int         lat;
  } vec_t;

  typedef struct {
    int          inst;
    logic [11:0] bits;
    int          nbits;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_transmitter #(.BAUD_RATE_NUMBER(16), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .clk_in(clk), .rst(rst[0]), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx(tx[0]), .tx_busy(busy[0])
  );
  uart_transmitter #(.BAUD_RATE_NUMBER(4), .PARITY(1), .STOP_BITS(1)) u_dut1 (
    .clk_in(clk), .rst(rst[1]), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx(tx[1]), .tx_busy(busy[1])
  );
  uart_transmitter #(.BAUD_RATE_NUMBER(4), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk_in(clk), .rst(rst[2]), .tx_data(data[2]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx(tx[2]), .tx_busy(busy[2])
  );
  uart_transmitter #(.BAUD_RATE_NUMBER(4), .PARITY(0), .STOP_BITS(1)) u_dut3 (
    .clk_in(clk), .rst(rst[3]), .tx_data(data[3]), .tx_valid(valid[3]),
    .tx_ready(ready[3]), .tx(tx[3]), .tx_busy(busy[3])
  );
  uart_transmitter #(.BAUD_RATE_NUMBER(8), .PARITY(0), .STOP_BITS(1)) u_dut4 (
    .clk_in(clk), .rst(rst[4]), .tx_data(data[4]), .tx_valid(valid[4]),
    .tx_ready(ready[4]), .tx(tx[4]), .tx_busy(busy[4])
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for ready, offers one byte, returns #1 after the accept edge.
  task automatic send(int i, logic [7:0] d, bit hold);
    int w = 0;
    @(negedge clk);
    while (!ready[i] && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (!ready[i]) chk($sformatf("ready wait inst%0d", i), {31'b0, ready[i]}, 32'd1);
    valid[i] = 1'b1;
    data[i]  = d;
    @(posedge clk);
    #1;
    if (!hold) valid[i] = 1'b0;
  endtask

  task automatic push_exp(int i, logic [7:0] d, logic par, int lat);
    exp_t e;
    e.inst = i;
    e.lat  = lat;
    e.bits = 12'hFFF;
    e.bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) e.bits[1+j] = d[j];
    e.nbits = 9;
    if (cfg_p[i]) begin
      e.bits[9] = par;
      e.nbits   = 10;
    end
    e.nbits += cfg_s[i];
    sb.push_back(e);
  endtask

  // Called #1 after the accept edge; consumes F*B+1 cycles, ending on the idle-gap cycle.
  task automatic check_frame(string name);
    exp_t e;
    int   b;
    int   c = 0;
    int   first_ready = 0;
    logic busy_bad = 1'b0;
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    b = cfg_b[e.inst];
    for (int k = 0; k < e.nbits; k++) begin
      logic act = e.bits[k];
      logic seen = 1'b0;
      for (int n = 0; n < b; n++) begin
        @(negedge clk);
        c++;
        if (!seen && tx[e.inst] !== e.bits[k]) begin
          act  = tx[e.inst];
          seen = 1'b1;
        end
        if (ready[e.inst] === 1'b1 && first_ready == 0) first_ready = c;
        if (busy[e.inst] !== ~ready[e.inst]) busy_bad = 1'b1;
      end
      chk($sformatf("%s bit%0d", name, k), {31'b0, act}, {31'b0, e.bits[k]});
    end
    @(negedge clk);
    c++;
    if (ready[e.inst] === 1'b1 && first_ready == 0) first_ready = c;
    chk({name, " ready return cycle"}, first_ready, e.lat);
    chk({name, " busy inverse"}, {31'b0, busy_bad}, 32'd0);
  endtask

  initial begin
    logic [4:0] low_seen;
    logic       ign_bad;

    vecs[0] = '{0, 8'h55, 1'b0, 161};
    vecs[1] = '{1, 8'hA5, 1'b0, 45};
    vecs[2] = '{2, 8'hA5, 1'b1, 49};
    vecs[3] = '{1, 8'h01, 1'b1, 45};
    vecs[4] = '{2, 8'h00, 1'b1, 49};
    vecs[5] = '{3, 8'h96, 1'b0, 41};
    vecs[6] = '{4, 8'hE7, 1'b0, 81};

    rst   = '1;
    valid = '0;
    for (int i = 0; i < NInst; i++) data[i] = 8'h00;

    repeat (2) begin
      @(negedge clk);
      for (int i = 0; i < NInst; i++) begin
        chk($sformatf("reset tx inst%0d", i), {31'b0, tx[i]}, 32'd1);
        chk($sformatf("reset ready inst%0d", i), {31'b0, ready[i]}, 32'd1);
        chk($sformatf("reset busy inst%0d", i), {31'b0, busy[i]}, 32'd0);
      end
    end
    rst = '0;

    low_seen = '0;
    repeat (100) begin
      @(negedge clk);
      low_seen |= ~tx | ~ready;
    end
    for (int i = 0; i < NInst; i++)
      chk($sformatf("idle line inst%0d", i), {31'b0, low_seen[i]}, 32'd0);

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].inst, vecs[v].data, 1'b0);
      push_exp(vecs[v].inst, vecs[v].data, vecs[v].par, vecs[v].lat);
      check_frame($sformatf("vec%0d", v));
    end

    // Back-to-back: valid held high across the frame boundary.
    send(3, 8'h00, 1'b1);
    data[3] = 8'hFF;
    push_exp(3, 8'h00, 1'b0, 41);
    check_frame("b2b first");
    chk("b2b idle gap", {31'b0, tx[3]}, 32'd1);
    @(posedge clk);
    #1;
    valid[3] = 1'b0;
    push_exp(3, 8'hFF, 1'b0, 41);
    check_frame("b2b second");

    // Offer made mid-frame must neither alter the byte nor queue a frame.
    send(4, 8'h3C, 1'b0);
    push_exp(4, 8'h3C, 1'b0, 81);
    fork
      check_frame("ignored");
      begin
        repeat (20) @(negedge clk);
        valid[4] = 1'b1;
        data[4]  = 8'hC3;
        repeat (20) @(negedge clk);
        valid[4] = 1'b0;
      end
    join
    ign_bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx[4] !== 1'b1 || ready[4] !== 1'b1) ign_bad = 1'b1;
    end
    chk("ignored no second frame", {31'b0, ign_bad}, 32'd0);

    // Reset during data bit 3 (frame cycles 33..40 at B=8).
    send(4, 8'hAA, 1'b0);
    repeat (35) @(negedge clk);
    rst[4] = 1'b1;
    @(posedge clk);
    #1;
    rst[4] = 1'b0;
    @(negedge clk);
    chk("midreset tx", {31'b0, tx[4]}, 32'd1);
    chk("midreset ready", {31'b0, ready[4]}, 32'd1);
    chk("midreset busy", {31'b0, busy[4]}, 32'd0);
    send(4, 8'h5A, 1'b0);
    push_exp(4, 8'h5A, 1'b0, 81);
    check_frame("after reset");

    chk("scoreboard drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial UART transmitter; the transmit-side counterpart of the UART receiver and its baud-rate generator. Accepts one byte per valid/ready handshake from the system side and shifts it out LSB-first on `tx` as a start bit, 8 data bits, an optional parity bit and 1 or 2 stop bits. Bit timing comes from an internal baud counter that is phase-aligned to each frame, so the first bit edge follows the handshake with fixed latency.

## Interface
- `BAUD_RATE_NUMBER`, default 10416: clock cycles per serial bit; legal values are 2 and above.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: legal values are 1 and 2.

Ports:
- `clk_in`  input  1: system clock. This is the block's only clock.
- `rst`  input  1: synchronous, active-high reset.
- `tx_data`  input  8: byte to send. Sampled only on the accept cycle.
- `tx_valid`  input  1: a byte is offered on `tx_data`.
- `tx_ready`  output  1: the block can accept a byte this cycle.
- `tx`  output  1: serial line. Idles high.
- `tx_busy`  output  1: a frame is in progress. This is the inverse of `tx_ready`.

## Operation
- **Reset values:** `tx`=1, `tx_ready`=1, `tx_busy`=0. State is IDLE. Baud counter is 0. Shift register is 0.
- **Handshake:** a byte is accepted on a rising edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_data` is latched into the shift register on that edge.
  - Later changes to `tx_data` or `tx_valid` have no effect.
  - `tx_valid` while busy is ignored and is not queued.
- **States:** IDLE → START → DATA → PARITY (only if `PARITY`≠0) → STOP → IDLE. The FSM leaves each non-IDLE state when the baud counter reaches `BAUD_RATE_NUMBER`-1.
- **DATA:** holds a bit index 0..7.
  - `tx` = shift register bit 0.
  - The register shifts right at each bit boundary.
  - The FSM exits after index 7.
- **PARITY:** `tx` is computed over the latched byte.
  - Even parity: `tx` = XOR of the 8 data bits.
  - Odd parity: `tx` = inverse of that XOR.
- **STOP:** `tx`=1 for `STOP_BITS` bit periods.
- **Output registers:** `tx` is registered, with no combinational path from inputs. `tx_ready` is registered and is 1 only in IDLE.
- **Baud counter:**
  - Width is $clog2(`BAUD_RATE_NUMBER`).
  - Cleared in IDLE.
  - Counts 0..`BAUD_RATE_NUMBER`-1 and wraps to 0 at each bit boundary.
  - No free-running phase is carried across frames.
- **Reset mid-frame:** on the edge where `rst`=1, all outputs return to their reset values. The partial frame is abandoned, `tx` goes high immediately and no stop bit is completed.

## Timing
- Let N be the accept edge and B = `BAUD_RATE_NUMBER`.
- **Frame length:** F = 1 + 8 + P + `STOP_BITS` bits, where P = 1 if parity is enabled, else 0.
- **Cycle N+1:** `tx`=0 (start bit) and `tx_ready`=0.
- **Bit k** (k=0 is the start bit) occupies cycles N+1+k·B through N+(k+1)·B. Every bit lasts exactly B cycles.
- **End of frame:** `tx_ready`=1 at cycle N+1+F·B.
- **Back-to-back frames:**
  - The earliest next accept is edge N+1+F·B.
  - The next start bit begins at cycle N+2+F·B.
  - The minimum idle gap between frames is exactly 1 cycle of `tx`=1.
- **Throughput:** one byte per F·B+1 cycles.

## Structure
- Shared package `uart_pkg` holds:
  - `DATA_BITS`=8;
  - the default `BAUD_RATE_NUMBER` of 10416, which is shared with the receiver and its baud-rate generator;
  - the parity encoding constants (`PARITY_NONE`/`EVEN`/`ODD`);
  - the FSM state enumeration `tx_state_t`.
- One sub-module, `uart_tx_baud_counter`.
  - Inputs: `clk_in`, `rst`, `enable`.
  - Output: a 1-cycle `bit_done` pulse when the count reaches B-1.
  - Clears whenever `enable`=0.
- The FSM, shift register and parity logic live in the top module.

## Test plan
- **Reset values:** hold `rst` for 2 cycles.
  - Required: `tx`=1, `tx_ready`=1 and `tx_busy`=0 throughout and after reset.
  - Required: `tx` stays 1 for 100 idle cycles.
- **Single byte, no parity** (B=16, 1 stop bit): send 0x55 at edge N.
  - Required `tx` sequence: 0,1,0,1,0,1,0,1,0,1, each level held exactly 16 cycles starting at N+1.
  - Required: `tx_ready` returns to 1 at N+161.
- **Parity** (B=4): send 0xA5.
  - With `PARITY`=1 (even), the parity bit must be 0.
  - With `PARITY`=2 (odd), it must be 1.
  - With `STOP_BITS`=2, `tx_ready` must return at N+1+12·4 = N+49.
- **Back-to-back** (B=4): hold `tx_valid`=1 with 0x00 then 0xFF.
  - Required: exactly one idle cycle with `tx`=1 between the stop bit of the first frame and the start bit of the second.
  - Required: the second frame's data bits are all 1.
- **Ignored input** (B=8): accept 0x3C.
  - Mid-frame, drive `tx_valid`=1 with `tx_data`=0xC3.
  - Required: the transmitted bits are 0x3C, and no second frame starts unless `tx_valid` is still high when `tx_ready` returns.
- **Reset mid-frame** (B=8): assert `rst` for 1 cycle during data bit 3.
  - Required: `tx`=1 and `tx_ready`=1 on the next cycle.
  - Required: a new byte accepted afterwards produces a full, correctly timed frame.
